// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: runs one WIDTH-bit ALU operation on a shared 1-bit slice, LSB first.
// Optional build macro OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf.
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_f,
    input  logic             slice_r,
    input  logic             slice_cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             cout_q, cout_d, zero_q, zero_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif
    logic             arith, last, run;
    logic [WIDTH-1:0] sr_next;

    // add (000) and sub (001) share the slice add path; everything else is a logic op
    assign arith   = op_q[2:1] == 2'b00;
    assign run     = state_q == RUN;
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign sr_next = {slice_r, sr_q[WIDTH-1:1]};

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf    = ovf_q;
`endif

    // Slice drive: subtract feeds ~B with carry-in 1 into the add function
    always_comb begin
        slice_a   = run & a_q[cnt_q];
        slice_b   = run & (b_q[cnt_q] ^ (op_q == 3'b001));
        slice_cin = run & carry_q;
        slice_f   = (run && !arith) ? op_q : 3'b000;
    end

    // Next-state and datapath: accept in IDLE, one bit per RUN cycle, publish on the last bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sr_d     = sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                op_d    = op;
                cnt_d   = '0;
                carry_d = op == 3'b001;
            end
            RUN: begin
                sr_d    = sr_next;
                carry_d = arith & slice_cout;
                cnt_d   = last ? cnt_q : cnt_q + CW'(1);
                if (last) begin
                    state_d  = DONE;
                    result_d = sr_next;
                    cout_d   = arith & slice_cout;
                    zero_d   = sr_next == '0;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d    = arith & (carry_q ^ slice_cout);
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous clear; an aborted operation leaves no trace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            sr_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb_alu_serial_sequencer: directed vector table plus abort/ignored-start sequences, with a 1-bit slice model.
module tb_alu_serial_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, zero;
    logic         slice_a, slice_b, slice_cin, slice_r, slice_cout;
    logic [2:0]   slice_f;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
`ifdef OVERFLOW_FLAG_EN
        .ovf(ovf),
`endif
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_f(slice_f),
        .slice_r(slice_r), .slice_cout(slice_cout)
    );

    // Reference 1-bit ALU slice
    always_comb begin
        slice_r    = 1'b0;
        slice_cout = 1'b0;
        case (slice_f)
            3'b000: begin
                slice_r    = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
            end
            3'b010: slice_r = slice_a & slice_b;
            3'b011: slice_r = slice_a | slice_b;
            3'b100: slice_r = ~(slice_a ^ slice_b);
            3'b101: slice_r = ~slice_a;
            3'b110: slice_r = slice_a;
            3'b111: slice_r = ~slice_b;
            default: slice_r = 1'bx;
        endcase
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         co, z, ov;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Issue one operation from IDLE and check latency, slice drive and final flags
    task automatic run_op(input vec_t v);
        int n;
        logic sub;
        sub = v.op == 3'b001;
        a = v.a; b = v.b; op = v.op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = ~v.b; op = ~v.op;
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        chk("slice_f", slice_f, (v.op[2:1] == 2'b00) ? 3'b000 : v.op);
        chk("slice_cin0", slice_cin, sub);
        chk("slice_a0", slice_a, v.a[0]);
        chk("slice_b0", slice_b, v.b[0] ^ sub);
        n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, W);
        chk("result", result, v.res);
        chk("cout", cout, v.co);
        chk("zero", zero, v.z);
`ifdef OVERFLOW_FLAG_EN
        chk("ovf", ovf, v.ov);
`endif
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("slice_f_idle", slice_f, 0);
        chk("result_hold", result, v.res);
    endtask

    initial begin
        int n, ndone, first;
        vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 8'h33, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b110, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 8'h0F, 8'hA0, 8'hAF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b101, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 0);
        chk("rst_slice", {slice_a, slice_b, slice_cin, slice_f}, 0);
`ifdef OVERFLOW_FLAG_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_op(vecs[i]);

        // start pulsed mid-run with new operands must be ignored
        a = 8'h10; b = 8'h20; op = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; ndone = 0; first = -1;
        repeat (3) begin @(negedge clk); n++; end
        a = 8'h00; b = 8'hFF; op = 3'b111; start = 1'b1;
        @(negedge clk); n++;
        start = 1'b0;
        repeat (3 * W) begin
            if (done) begin ndone++; if (first < 0) first = n; end
            @(negedge clk); n++;
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_latency", first, W);
        chk("ign_result", result, 8'h30);
        chk("ign_busy", busy, 0);

        // asynchronous abort at bit 3 of an add
        a = 8'hFF; b = 8'h01; op = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 0);
        ndone = 0;
        repeat (2 * W) begin @(negedge clk); if (done) ndone++; end
        rst_n = 1'b1;
        repeat (2 * W) begin @(negedge clk); if (done) ndone++; end
        chk("abort_nodone", ndone, 0);
        run_op(vecs[8]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
